// File: rtl/bit_serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// bit_serial_subtractor_if
//
// Purpose: bundles the request/result signals of the bit-serial subtractor so
// a controller and the subtractor can be connected by a single port.
//
// Signals:
//   start  controller -> subtractor  request, looked at only while idle
//   a, b   controller -> subtractor  minuend / subtrahend (WIDTH bits)
//   bin    controller -> subtractor  borrow-in
//   busy   subtractor -> controller  serial operation in progress
//   done   subtractor -> controller  one-cycle pulse, diff/bout(/ovf) valid
//   diff   subtractor -> controller  difference (WIDTH bits)
//   bout   subtractor -> controller  final borrow-out
//   ovf    subtractor -> controller  signed overflow, only when
//                                    SERIAL_SUB_OVF_EN is defined
//
// Modports: master (controller side), slave (subtractor side).
// Optional feature macro: SERIAL_SUB_OVF_EN
// ----------------------------------------------------------------------------
interface bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/bit_serial_subtractor.sv
// ----------------------------------------------------------------------------
// bit_serial_subtractor
//
// Purpose: computes diff = a - b - bin (mod 2^WIDTH) one bit per clock, LSB
// first, with one full-subtractor cell and a registered borrow. Operands are
// captured in parallel when a request is accepted, then shifted out serially.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, highest priority
//   bus   slave modport of bit_serial_subtractor_if
//         (start/a/b/bin in; busy/done/diff/bout[/ovf] out)
//
// Timing: start accepted at edge E0 -> busy for WIDTH cycles -> done high for
// the single cycle after edge E(WIDTH). One operation per WIDTH+2 cycles.
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag.
// ----------------------------------------------------------------------------
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bit_serial_subtractor_if.slave  bus
);
    localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs.
    logic d_bit;
    logic bnext;
    assign d_bit = ra_q[0] ^ rb_q[0] ^ br_q;
    assign bnext = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);

    logic last_bit;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    br_d    = bus.bin;
                    diff_d  = '0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    sa_d    = bus.a[WIDTH-1];
                    sb_d    = bus.b[WIDTH-1];
                    ovf_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so the LSB-first stream ends up
                // right-aligned after WIDTH shifts.
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                ra_d   = ra_q >> 1;
                rb_d   = rb_q >> 1;
                br_d   = bnext;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    bout_d  = bnext;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // Operand signs differ and the result sign left the
                    // minuend's sign.
                    ovf_d   = (sa_q ^ sb_q) & (d_bit ^ sa_q);
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy is registered yet still tracks the state register exactly.
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_subtractor
//
// Self-checking bench for bit_serial_subtractor (WIDTH=8). Results are checked
// against plain integer arithmetic: a - b - bin modulo 256, unsigned borrow
// as a < b + bin, and the signed-overflow rule on operand/result signs.
// Honours SERIAL_SUB_OVF_EN for the ovf port.
// ----------------------------------------------------------------------------
module tb_bit_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit_serial_subtractor_if #(.WIDTH(W)) bus ();

    bit_serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model, integer arithmetic only.
    function automatic logic [W-1:0] ref_diff(input int a, input int b, input int bi);
        int r;
        r = (a - b - bi) % 256;
        if (r < 0) r += 256;
        return r[W-1:0];
    endfunction

    function automatic logic ref_bout(input int a, input int b, input int bi);
        return (a < b + bi);
    endfunction

    function automatic logic ref_ovf(input int a, input int b, input int bi);
        logic sa, sb, sr;
        logic [W-1:0] r;
        r  = ref_diff(a, b, bi);
        sa = (a >= 128);
        sb = (b >= 128);
        sr = r[W-1];
        return (sa != sb) && (sr != sa);
    endfunction

    task automatic check_result(input string tag, input int a, input int b, input int bi);
        check({tag, ".diff"}, 32'(bus.diff), 32'(ref_diff(a, b, bi)));
        check({tag, ".bout"}, 32'(bus.bout), 32'(ref_bout(a, b, bi)));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, 32'(bus.ovf), 32'(ref_ovf(a, b, bi)));
`endif
    endtask

    // One full operation: pulse start, wait for done (bounded), check timing
    // and results. Returns at a negedge with the DUT back in IDLE.
    task automatic do_op(input string tag, input int a, input int b, input int bi,
                         input bit chk_timing);
        int edges, busy_cnt;
        bit got;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a[W-1:0];
        bus.b     = b[W-1:0];
        bus.bin   = bi[0];
        @(posedge clk);          // E0
        edges    = 1;
        busy_cnt = 0;
        got      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            edges++;
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        if (got) begin
            $display("op %s: a=%0d b=%0d bin=%0d -> diff=%0h bout=%0b edges=%0d",
                     tag, a, b, bi, bus.diff, bus.bout, edges);
            check_result(tag, a, b, bi);
            if (chk_timing) begin
                check({tag, ".latency"}, 32'(edges), 32'(W + 1));
                check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
            end
            @(negedge clk);
            check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        end
    endtask

    int done_cycles[$];

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.diff", 32'(bus.diff), 32'd0);
        check("rst.bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst.ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;

        // Directed cases.
        do_op("d200_55",  200,  55, 0, 1'b1);
        do_op("d55_200",   55, 200, 0, 1'b0);
        do_op("d0_0_b1",    0,   0, 1, 1'b0);
        do_op("dFF_FF_b1", 255, 255, 1, 1'b0);
        do_op("d80_01",   128,   1, 0, 1'b0);
        do_op("d7F_FF",   127, 255, 0, 1'b0);

        // Randomized cases.
        for (int i = 0; i < 20; i++) begin
            int ra, rb, rbi;
            ra  = int'($urandom_range(0, 255));
            rb  = int'($urandom_range(0, 255));
            rbi = int'($urandom_range(0, 1));
            do_op($sformatf("rnd%0d", i), ra, rb, rbi, (i % 5) == 0);
        end

        // Extra start pulses during RUN and DONE are ignored.
        begin
            int dn;
            bit got;
            @(negedge clk);
            bus.start = 1'b1; bus.a = 8'd10; bus.b = 8'd3; bus.bin = 1'b0;
            @(posedge clk);                       // E0
            @(negedge clk); bus.start = 1'b0;
            repeat (3) @(posedge clk);            // after RUN cycle 3
            @(negedge clk); bus.start = 1'b1; bus.a = 8'd99;
            @(posedge clk);
            @(negedge clk); bus.start = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.done) begin got = 1'b1; break; end
                @(negedge clk);
            end
            check("ign.done_seen", 32'(got), 32'd1);
            check("ign.diff", 32'(bus.diff), 32'd7);
            bus.start = 1'b1;                      // pulse during DONE
            @(negedge clk);
            bus.start = 1'b0;
            dn = 0;
            for (int i = 0; i < 15; i++) begin
                if (bus.done || bus.busy) dn++;
                @(negedge clk);
            end
            check("ign.no_restart", 32'(dn), 32'd0);
            check("ign.diff_hold", 32'(bus.diff), 32'd7);
            $display("op ignore-start: diff=%0h", bus.diff);
        end

        // Continuous start: done pulses spaced WIDTH+2 cycles apart.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd20; bus.b = 8'd5; bus.bin = 1'b0;
        for (int i = 0; i < 40 && done_cycles.size() < 3; i++) begin
            @(negedge clk);
            if (bus.done) done_cycles.push_back(cyc);
        end
        bus.start = 1'b0;
        check("b2b.count", 32'(done_cycles.size()), 32'd3);
        if (done_cycles.size() == 3) begin
            check("b2b.gap1", 32'(done_cycles[1] - done_cycles[0]), 32'(W + 2));
            check("b2b.gap2", 32'(done_cycles[2] - done_cycles[1]), 32'(W + 2));
            $display("op back-to-back: done at cycles %0d %0d %0d",
                     done_cycles[0], done_cycles[1], done_cycles[2]);
        end
        repeat (15) @(negedge clk);

        // Reset in the middle of RUN aborts the operation.
        begin
            int dn;
            @(negedge clk);
            bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd1; bus.bin = 1'b0;
            @(posedge clk);                       // E0
            @(negedge clk); bus.start = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk); rst = 1'b1;           // applied at 4th RUN edge
            @(posedge clk);
            @(negedge clk); rst = 1'b0;
            check("abort.busy", 32'(bus.busy), 32'd0);
            check("abort.diff", 32'(bus.diff), 32'd0);
            check("abort.bout", 32'(bus.bout), 32'd0);
            dn = 0;
            for (int i = 0; i < 15; i++) begin
                if (bus.done) dn++;
                @(negedge clk);
            end
            check("abort.no_done", 32'(dn), 32'd0);
            $display("op abort: busy=%0b diff=%0h", bus.busy, bus.diff);
        end
        do_op("post_abort", 5, 9, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
